// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the data-RAM access controller.
// State codes are plain localparams so legacy decoders can compare against them directly.
// RAM_BYTES helper gives the byte span of a RAM with a given word-address width.
package mem_bus_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t TURN   = 3'd1;
  localparam state_t WRITE  = 3'd2;
  localparam state_t READ   = 3'd3;
  localparam state_t RDWAIT = 3'd4;
  localparam state_t ERR    = 3'd5;
  localparam state_t RESP   = 3'd6;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Byte span of a RAM with 2**aw 32-bit words; one extra bit so the compare never wraps.
  function automatic logic [32:0] ram_bytes(input int unsigned aw);
    return 33'd4 << aw;
  endfunction

endpackage

// File: rtl/ram_addr_check.sv
// Purpose: map a CPU byte address onto a RAM word address and flag bad requests.
// Latency: purely combinational.
// Backpressure: none; result is valid whenever byte_addr is.
module ram_addr_check
  import mem_bus_pkg::*;
#(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic [31:0]           byte_addr,
  output logic [ADDR_WIDTH-1:0] word_addr,
  output logic                  misaligned,
  output logic                  out_of_range
);

  logic [31:0] off;

  // Offset wraps modulo 2**32, so addresses below BASE_ADDR land far out of range.
  assign off          = byte_addr - BASE_ADDR;
  assign word_addr    = off[ADDR_WIDTH+1:2];
  assign misaligned   = (off[1:0] != 2'b00);
  assign out_of_range = ({1'b0, off} >= ram_bytes(ADDR_WIDTH));

endmodule

// File: rtl/ram_bus_ctrl.sv
// Purpose: single-outstanding access controller for the inout-bus data RAM.
// Latency: accept cycle to resp_valid is 2 (write/error), 3 (read), 4 (read after write).
// Backpressure: req_ready only in IDLE; response held in RESP until resp_ready.
module ram_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int          ADDR_WIDTH = 12,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                  CLK,
  input  logic                  Rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  inout  wire  [DATA_WIDTH-1:0] Mem_Data,
  output logic [ADDR_WIDTH-1:0] Mem_Addr,
  output logic                  Mem_R_W,
  output logic                  Mem_CS
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic                  last_wr;
  logic                  accept;

  logic [ADDR_WIDTH-1:0] chk_word;
  logic                  chk_mis;
  logic                  chk_oor;

  ram_addr_check #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BASE_ADDR  (BASE_ADDR)
  ) u_addr_check (
    .byte_addr    (req_addr),
    .word_addr    (chk_word),
    .misaligned   (chk_mis),
    .out_of_range (chk_oor)
  );

  // Ready is held low while reset is asserted even though the state already reads IDLE.
  assign req_ready = Rst & (state == IDLE);
  assign accept    = req_valid & req_ready;

  // Access sequencer: one request at a time, TURN inserted when a read follows a write
  // so the controller's write drivers are off for a full cycle before the RAM drives.
  always_ff @(posedge CLK or negedge Rst) begin
    if (!Rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      last_wr <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q  <= chk_word;
            wdata_q <= req_wdata;
            rdata_q <= '0;
            err_q   <= 1'b0;
            if (chk_mis | chk_oor) state <= ERR;
            else if (req_we)       state <= WRITE;
            else if (last_wr)      state <= TURN;
            else                   state <= READ;
          end
        end
        TURN: begin
          last_wr <= 1'b0;
          state   <= READ;
        end
        WRITE: begin
          last_wr <= 1'b1;
          state   <= RESP;
        end
        READ:   state <= RDWAIT;
        RDWAIT: begin
          rdata_q <= Mem_Data;
          state   <= RESP;
        end
        ERR: begin
          err_q <= 1'b1;
          state <= RESP;
        end
        RESP: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign resp_valid = (state == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  assign Mem_CS   = (state == WRITE) | (state == READ) | (state == RDWAIT);
  assign Mem_R_W  = (state == WRITE) ? RW_WRITE : RW_READ;
  assign Mem_Addr = addr_q;

  // The only driver of the shared bus from this side.
  assign Mem_Data = (state == WRITE) ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule
